// File: rtl/led_blink_ctrl.sv
// Button-driven LED blink controller: synchronizes and debounces a push-button,
// cycles OFF/SLOW/FAST/ON on each accepted press and drives a glitch-free LED level.
module led_blink_ctrl #(
   parameter int SLOW_HALF = 25_000_000,
   parameter int FAST_HALF = 6_250_000,
   parameter int DB_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_in,
   output logic       led,
   output logic [1:0] mode,
   output logic       btn_pulse
);

   localparam int DBW = $clog2(DB_CYCLES);
   localparam int PW  = $clog2(SLOW_HALF);

   localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
   localparam logic [PW-1:0]  SLOW_LAST = PW'(SLOW_HALF - 1);
   localparam logic [PW-1:0]  FAST_LAST = PW'(FAST_HALF - 1);

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_SLOW = 2'b01,
      MODE_FAST = 2'b10,
      MODE_ON   = 2'b11
   } mode_t;

   mode_t state;
   mode_t state_next;

   logic           sync1;
   logic           sync2;
   logic           stable;
   logic [DBW-1:0] db_cnt;
   logic           db_mismatch;
   logic           db_expire;
   logic           accept_press;
   logic [PW-1:0]  phase_cnt;
   logic [PW-1:0]  phase_last;

   // Two-flop synchronizer for the asynchronous button input.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   assign db_mismatch  = (sync2 != stable);
   assign db_expire    = db_mismatch && (db_cnt == DB_LAST);
   assign accept_press = db_expire && sync2;

   // A level change is accepted only after DB_CYCLES consecutive mismatching cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stable    <= 1'b0;
         db_cnt    <= '0;
         btn_pulse <= 1'b0;
      end else begin
         btn_pulse <= accept_press;
         if (!db_mismatch) begin
            db_cnt <= '0;
         end else if (db_expire) begin
            stable <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DBW'(1);
         end
      end
   end

   // Mode FSM: state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= MODE_SLOW;
      end else begin
         state <= state_next;
      end
   end

   // Mode FSM: advance one step per accepted press, wrapping ON back to OFF.
   always_comb begin
      state_next = state;
      if (btn_pulse) begin
         case (state)
            MODE_OFF:  state_next = MODE_SLOW;
            MODE_SLOW: state_next = MODE_FAST;
            MODE_FAST: state_next = MODE_ON;
            MODE_ON:   state_next = MODE_OFF;
            default:   state_next = MODE_SLOW;
         endcase
      end
   end

   assign mode       = state;
   assign phase_last = (state == MODE_FAST) ? FAST_LAST : SLOW_LAST;

   // Blink engine; a mode change restarts the phase and wins over a same-edge toggle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         phase_cnt <= '0;
         led       <= 1'b0;
      end else if (btn_pulse) begin
         phase_cnt <= '0;
         led       <= (state_next == MODE_ON);
      end else begin
         case (state)
            MODE_OFF: begin
               phase_cnt <= '0;
               led       <= 1'b0;
            end
            MODE_ON: begin
               phase_cnt <= '0;
               led       <= 1'b1;
            end
            default: begin
               if (phase_cnt == phase_last) begin
                  phase_cnt <= '0;
                  led       <= ~led;
               end else begin
                  phase_cnt <= phase_cnt + PW'(1);
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_blink_ctrl.sv
// Directed bench for led_blink_ctrl with short blink and debounce periods;
// every expected value is derived by hand from the edge-level timing.
module tb_led_blink_ctrl;

   localparam int SLOW_HALF = 8;
   localparam int FAST_HALF = 2;
   localparam int DB_CYCLES = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       btn_in = 1'b0;
   logic       led;
   logic [1:0] mode;
   logic       btn_pulse;

   int errors = 0;
   int checks = 0;
   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   led_blink_ctrl #(
      .SLOW_HALF(SLOW_HALF),
      .FAST_HALF(FAST_HALF),
      .DB_CYCLES(DB_CYCLES)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .led(led),
      .mode(mode),
      .btn_pulse(btn_pulse)
   );

   // Hold the button high for 'hold' edges; report pulse count and edge of last pulse.
   task automatic press(input int hold, output int pulses, output int last_k);
      btn_in = 1'b1;
      pulses = 0;
      last_k = 0;
      for (int k = 1; k <= hold; k++) begin
         @(posedge clk); #1;
         if (btn_pulse) begin
            pulses++;
            last_k = k;
         end
      end
   endtask

   task automatic release_btn(input int n, output int pulses);
      btn_in = 1'b0;
      pulses = 0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (btn_pulse) pulses++;
      end
   endtask

   task automatic test_reset();
      logic exp_led;
      repeat (3) @(posedge clk);
      #4 rst = 1'b1;
      #1;
      checks++; if (led !== 1'b0) begin errors++; $display("FAIL reset_led: got %b want 0", led); end
      checks++; if (mode !== 2'b01) begin errors++; $display("FAIL reset_mode: got %b want 01", mode); end
      checks++; if (btn_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b want 0", btn_pulse); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 1; k <= 24; k++) begin
         @(posedge clk); #1;
         exp_led = ((k >= 8) && (k < 16)) || (k >= 24);
         if ((k % 8 == 0) || (k % 8 == 7)) begin
            checks++;
            if (led !== exp_led) begin
               errors++; $display("FAIL slow_blink edge %0d: got %b want %b", k, led, exp_led);
            end
         end
      end
      checks++; if (mode !== 2'b01) begin errors++; $display("FAIL slow_mode: got %b want 01", mode); end
   endtask

   task automatic test_glitch();
      int p;
      btn_in = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      release_btn(15, p);
      checks++; if (p != 0) begin errors++; $display("FAIL glitch_pulse: got %0d pulses want 0", p); end
      checks++; if (mode !== 2'b01) begin errors++; $display("FAIL glitch_mode: got %b want 01", mode); end
   endtask

   task automatic test_bouncy();
      int p;
      logic exp_led;
      p = 0;
      for (int i = 0; i < 10; i++) begin
         btn_in = (i % 2 == 0);
         repeat (2) begin
            @(posedge clk); #1;
            if (btn_pulse) p++;
         end
      end
      checks++; if (p != 0) begin errors++; $display("FAIL bounce_pulse: got %0d pulses want 0", p); end
      btn_in = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(posedge clk); #1;
         checks++;
         if (btn_pulse !== (k == 6)) begin
            errors++; $display("FAIL bounce_strobe edge %0d: got %b want %b", k, btn_pulse, (k == 6));
         end
         if (k == 6) begin
            checks++; if (mode !== 2'b01) begin errors++; $display("FAIL bounce_mode_early: got %b want 01", mode); end
         end
         if (k >= 7) begin
            exp_led = (((k - 7) / 2) % 2) == 1;
            checks++;
            if (mode !== 2'b10) begin errors++; $display("FAIL bounce_mode edge %0d: got %b want 10", k, mode); end
            checks++;
            if (led !== exp_led) begin errors++; $display("FAIL fast_blink edge %0d: got %b want %b", k, led, exp_led); end
         end
      end
   endtask

   task automatic test_mode_wrap();
      int p;
      int lk;
      int bad;
      logic [1:0] exp_mode;
      exp_q.push_back(2'b11);
      exp_q.push_back(2'b00);
      exp_q.push_back(2'b01);
      release_btn(10, p);
      checks++; if (p != 0) begin errors++; $display("FAIL wrap_first_release: got %0d pulses want 0", p); end
      for (int m = 0; m < 3; m++) begin
         press(8, p, lk);
         exp_mode = exp_q.pop_front();
         checks++; if (p != 1 || lk != 6) begin errors++; $display("FAIL wrap_press %0d: got %0d pulses at %0d want 1 at 6", m, p, lk); end
         checks++; if (mode !== exp_mode) begin errors++; $display("FAIL wrap_mode %0d: got %b want %b", m, mode, exp_mode); end
         release_btn(10, p);
         checks++; if (p != 0) begin errors++; $display("FAIL wrap_release %0d: got %0d pulses want 0", m, p); end
         if (m < 2) begin
            bad = 0;
            for (int k = 0; k < 50; k++) begin
               @(posedge clk); #1;
               if (led !== (exp_mode == 2'b11)) bad++;
            end
            checks++; if (bad != 0) begin errors++; $display("FAIL wrap_led_const %0d: got %0d bad cycles want 0", m, bad); end
         end
      end
   endtask

   task automatic test_release();
      int p;
      int lk;
      press(30, p, lk);
      checks++; if (p != 1 || lk != 6) begin errors++; $display("FAIL long_press: got %0d pulses at %0d want 1 at 6", p, lk); end
      checks++; if (mode !== 2'b10) begin errors++; $display("FAIL long_press_mode: got %b want 10", mode); end
      release_btn(10, p);
      checks++; if (p != 0) begin errors++; $display("FAIL long_release: got %0d pulses want 0", p); end
      checks++; if (mode !== 2'b10) begin errors++; $display("FAIL long_release_mode: got %b want 10", mode); end
   endtask

   task automatic test_collision();
      int p;
      int lk;
      logic prev;
      logic found;
      for (int m = 0; m < 3; m++) begin
         press(8, p, lk);
         checks++; if (p != 1 || lk != 6) begin errors++; $display("FAIL coll_setup %0d: got %0d pulses at %0d want 1 at 6", m, p, lk); end
         release_btn(10, p);
      end
      checks++; if (mode !== 2'b01) begin errors++; $display("FAIL coll_setup_mode: got %b want 01", mode); end
      found = 1'b0;
      prev  = led;
      for (int i = 0; i < 40 && !found; i++) begin
         @(posedge clk); #1;
         if (prev === 1'b1 && led === 1'b0) found = 1'b1;
         prev = led;
      end
      checks++; if (!found) begin errors++; $display("FAIL coll_sync: got no led fall within 40 cycles want one"); end
      @(posedge clk); #1;
      btn_in = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clk); #1;
         if (k == 6) begin
            checks++; if (btn_pulse !== 1'b1) begin errors++; $display("FAIL coll_pulse: got %b want 1", btn_pulse); end
         end
         if (k == 7) begin
            checks++; if (mode !== 2'b10) begin errors++; $display("FAIL coll_mode: got %b want 10", mode); end
            checks++; if (led !== 1'b0) begin errors++; $display("FAIL coll_led_entry: got %b want 0", led); end
         end
         if (k == 8) begin
            checks++; if (led !== 1'b0) begin errors++; $display("FAIL coll_led_hold: got %b want 0", led); end
         end
         if (k == 9) begin
            checks++; if (led !== 1'b1) begin errors++; $display("FAIL coll_led_rise: got %b want 1", led); end
         end
      end
   endtask

   task automatic test_async_reset();
      checks++; if (led !== 1'b1) begin errors++; $display("FAIL areset_pre_led: got %b want 1", led); end
      #3 rst = 1'b1;
      #1;
      checks++; if (led !== 1'b0) begin errors++; $display("FAIL areset_led: got %b want 0", led); end
      checks++; if (mode !== 2'b01) begin errors++; $display("FAIL areset_mode: got %b want 01", mode); end
      checks++; if (btn_pulse !== 1'b0) begin errors++; $display("FAIL areset_pulse: got %b want 0", btn_pulse); end
      btn_in = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         if (k == 7) begin
            checks++; if (led !== 1'b0) begin errors++; $display("FAIL areset_slow_low: got %b want 0", led); end
         end
         if (k == 8) begin
            checks++; if (led !== 1'b1) begin errors++; $display("FAIL areset_slow_rise: got %b want 1", led); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_glitch();
      test_bouncy();
      test_mode_wrap();
      test_release();
      test_collision();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_blink_ctrl.md
# led_blink_ctrl

Upstream LED pattern source for the Ethernet_and_LedBlink example. It debounces a raw push-button and steps through four LED modes on each press: OFF, SLOW, FAST and ON. It drives an active-high LED level `led`, which the following inverter stage turns into the board's active-low LED pin. All state is in the PL clock domain.

## Interface
Parameters:
- `SLOW_HALF`, default 25_000_000: clock cycles per half-period in SLOW mode (≥2).
- `FAST_HALF`, default 6_250_000: clock cycles per half-period in FAST mode (≥2, < SLOW_HALF).
- `DB_CYCLES`, default 1_000_000: consecutive cycles a changed button level must persist before it is accepted (≥2).

Ports:
- `clk`  in  1  single clock; all logic rises on it.
- `rst`  in  1  reset, asynchronous, active-high.
- `btn_in`  in  1  raw button, active-high, asynchronous to `clk`, may bounce.
- `led`  out  1  active-high LED level; feeds the inverter stage.
- `mode`  out  2  current mode: 00 OFF, 01 SLOW, 10 FAST, 11 ON.
- `btn_pulse`  out  1  one-cycle strobe on each accepted press (0→1 of the debounced level).

## Operation
- Synchronizer: two flops on `btn_in`, giving `sync2`. Both reset to 0.
- Debouncer:
  - Holds `stable` (reset 0) and a counter sized `$clog2(DB_CYCLES)`.
  - While `sync2 == stable`, the counter is 0.
  - While they differ, the counter increments each cycle.
  - On the edge where the counter is `DB_CYCLES-1` and a mismatch is still present, `stable` takes `sync2` and the counter clears.
  - Any return to a match before then clears the counter, so no change is accepted.
- `btn_pulse`: registered, reset 0. It is 1 for exactly the one cycle after the edge on which `stable` goes 0→1. The 1→0 release never pulses.
- Mode FSM:
  - `mode` resets to 01 (SLOW).
  - On each edge where `btn_pulse` is 1, mode advances OFF→SLOW→FAST→ON→OFF, wrapping 11→00.
- Blink engine:
  - Phase counter sized `$clog2(SLOW_HALF)`; blink register drives `led`. Both reset to 0.
  - In SLOW or FAST, the counter counts 0..HALF-1 using the current mode's HALF.
  - At HALF-1 the counter wraps to 0 and `led` toggles.
  - In OFF: counter is held at 0, `led` = 0.
  - In ON: counter is held at 0, `led` = 1.
- Mode-change edge:
  - The counter clears.
  - `led` takes its entry value: 0 for OFF, SLOW or FAST; 1 for ON.
  - This overrides a terminal-count toggle on the same edge.
- Reset asserted mid-operation clears every register immediately, without waiting for a clock edge.

## Timing
- Reset values: `led`=0, `mode`=01, `btn_pulse`=0.
- Reset release, SLOW mode:
  - `led` rises on the SLOW_HALF-th rising edge after `rst` deasserts.
  - After that, the full period is 2·SLOW_HALF with 50% duty.
- FAST mode period: 2·FAST_HALF cycles. The first rise is FAST_HALF edges after the mode-change edge.
- Press latency:
  - `btn_in` high, first sampled at edge 1, gives `sync2`=1 after edge 2.
  - `stable` and `btn_pulse` go 1 after edge 2+DB_CYCLES.
  - `mode` updates one edge later.
- A press is not re-accepted until `stable` has returned to 0, which needs a full DB_CYCLES low period.
- Output `led` is glitch-free because it comes straight from a flop.

## Test plan
Bench parameters: SLOW_HALF=8, FAST_HALF=2, DB_CYCLES=4.

1. Reset and SLOW blink: pulse `rst` → `led`=0, `mode`=01, `btn_pulse`=0 asynchronously. After release, `led` goes 1 at edge 8, 0 at edge 16, 1 at edge 24.
2. Bouncy press: `btn_in` toggles every 2 cycles for 20 cycles, then holds 1 → exactly one `btn_pulse`, 6 edges after the final rise is sampled. `mode` goes 01→10, and `led` then toggles every 2 cycles.
3. Mode wrap: three further clean presses → `mode` goes 11 (`led` constant 1 for 50 cycles), then 00 (`led` constant 0), then 01.
4. Glitch rejection: `btn_in` high for 3 cycles, then low → no `btn_pulse`, `mode` unchanged.
5. Release and collision:
   - Hold `btn_in` 30 cycles, then release → one pulse on the press, none on the release.
   - Time a press so `btn_pulse` coincides with a SLOW terminal count → `led`=0 and counter=0 on FAST entry.
6. Async reset mid-FAST with `led`=1: raise `rst` between clock edges → `led`=0 and `mode`=01 before the next edge.
